// File: rtl/mem_operand_fetcher_pkg.sv
// Shared widths, FSM encodings and the operand-pair entry layout
// for the memory operand fetcher.
package mem_operand_fetcher_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int SEL_WIDTH  = 4;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  localparam logic [SEL_WIDTH-1:0] ROM_SECTOR = 4'd15;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] a;
  } op_pair_t;

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [LEN_WIDTH-1:0]  idx
  );
    return base + idx[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mem_operand_fetcher_if.sv
// Operand-pair valid/ready stream between the fetcher and the
// MAC datapath.
interface mem_operand_fetcher_if;
  import mem_operand_fetcher_pkg::*;

  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_last;

  modport master (
    output op_valid,
    output op_a,
    output op_b,
    output op_last,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_a,
    input  op_b,
    input  op_last,
    output op_ready
  );

endinterface

// File: rtl/mem_operand_fetcher_fifo.sv
// Small synchronous FIFO holding {op_last, op_b, op_a} entries;
// head entry is presented combinationally.
module operand_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 33,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mem_operand_fetcher.sv
// Burst read initiator: walks N addresses over two sectors and streams
// operand pairs. Optional stall counter: FETCH_STALL_CNT_EN.
module mem_operand_fetcher
  import mem_operand_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  cfg_sel_1,
  input  logic [SEL_WIDTH-1:0]  cfg_sel_2,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_add_1,
  output logic [ADDR_WIDTH-1:0] read_add_2,
  output logic [SEL_WIDTH-1:0]  read_sector_selector_1,
  output logic [SEL_WIDTH-1:0]  read_sector_selector_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  mem_operand_fetcher_if.master op
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [SEL_WIDTH-1:0]  sel1_q;
  logic [SEL_WIDTH-1:0]  sel2_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [ADDR_WIDTH-1:0] radd_q;
  logic [SEL_WIDTH-1:0]  rsel1_q;
  logic [SEL_WIDTH-1:0]  rsel2_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  op_pair_t      push_pair;
  op_pair_t      head_pair;

  logic          accept;
  logic          pop;
  logic          issue;
  logic          drain_ok;
  logic [OW-1:0] occ;

  assign accept = (state_q == S_IDLE) && start;
  assign pop    = !fifo_empty && op.op_ready;

  // Slots committed after this edge; a same-cycle pop frees one
  assign occ = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);

  assign issue = (state_q == S_FETCH)
              && (issued_q != len_q)
              && (occ < OW'(FIFO_DEPTH));

  assign drain_ok = !inflight_q
                 && (fifo_empty || (fifo_count == CW'(1) && pop));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_ok) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      sel1_q          <= '0;
      sel2_q          <= '0;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      radd_q          <= '0;
      rsel1_q         <= '0;
      rsel2_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel1_q   <= cfg_sel_1;
        sel2_q   <= cfg_sel_2;
        base_q   <= cfg_base;
        len_q    <= cfg_len;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
      if (issue) begin
        radd_q  <= wrap_addr(base_q, issued_q);
        rsel1_q <= sel1_q;
        rsel2_q <= sel2_q;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && (issued_q == len_q - 1'b1);
    end
  end

  assign push_pair = '{
    last: inflight_last_q,
    b:    read_data_2,
    a:    read_data_1
  };

  operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(op_pair_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .wdata (push_pair),
    .pop   (pop),
    .rdata (head_pair),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign op.op_valid = !fifo_empty;
  assign op.op_a     = head_pair.a;
  assign op.op_b     = head_pair.b;
  assign op.op_last  = head_pair.last;

  assign busy                   = (state_q != S_IDLE);
  assign done                   = (state_q == S_DONE);
  assign read_add_1             = radd_q;
  assign read_add_2             = radd_q;
  assign read_sector_selector_1 = rsel1_q;
  assign read_sector_selector_2 = rsel2_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (!fifo_empty && !op.op_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
